driver_cfg_writer: RTL and testbench

// Upstream command stage for driver_core. Accepts config commands on a valid/ready bus,

---
 rtl/driver_cfg_writer_if.sv | 10 +
 rtl/driver_cfg_writer.sv | 158 +++++++++++++++
 tb/tb_driver_cfg_writer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/driver_cfg_writer_if.sv
// driver_cfg_writer_if: valid/ready config-command bus feeding driver_cfg_writer
interface driver_cfg_writer_if #(parameter int MAL = 6);
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [MAL-1:0] cmd_addr, cmd_row, cmd_col;
  logic [15:0] cmd_data;
  logic [2:0] cmd_mask;
  modport master (output cmd_valid, cmd_op, cmd_addr, cmd_row, cmd_col, cmd_data, cmd_mask, input cmd_ready);
  modport slave (input cmd_valid, cmd_op, cmd_addr, cmd_row, cmd_col, cmd_data, cmd_mask, output cmd_ready);
endinterface

// File: rtl/driver_cfg_writer.sv
// driver_cfg_writer: buffers config commands and drives driver_core *_a inputs with setup/strobe/hold timing
module driver_cfg_writer #(
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int SETUP_CYCLES = 4,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  driver_cfg_writer_if.slave cmd,
  input  logic estop,
  output logic busy,
  output logic [2:0] mask_select_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] mem_address_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] row_select_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] col_select_a,
  output logic [MEM_ADDRESS_LENGTH-1:0] mem_sel_col_address_a,
  output logic [15:0] data_in_a,
  output logic row_col_select_a,
  output logic mem_write_n_a,
  output logic mem_dot_write_n_a,
  output logic mem_sel_write_n_a,
  output logic output_active_a,
  output logic inverter_select_a
);
  localparam int MAL = MEM_ADDRESS_LENGTH;
  localparam int W = 2 + 3 * MAL + 19;
  localparam int SM = SETUP_CYCLES > STROBE_CYCLES ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MX = SM > HOLD_CYCLES ? SM : HOLD_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam logic [1:0] OP_MEM = 2'd0, OP_DOT = 2'd1, OP_SEL = 2'd2, OP_CTRL = 2'd3;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d, fcnt_q, fcnt_d;
  logic rd_q, rd_d, wr_q, wr_d;
  logic [W-1:0] buf_q [2];
  logic [W-1:0] buf_d [2];
  logic [2:0] mask_select_q, mask_select_d;
  logic [MAL-1:0] mem_address_q, mem_address_d, row_select_q, row_select_d;
  logic [MAL-1:0] col_select_q, col_select_d, mem_sel_col_address_q, mem_sel_col_address_d;
  logic [15:0] data_in_q, data_in_d;
  logic row_col_select_q, row_col_select_d, output_active_q, output_active_d;
  logic inverter_select_q, inverter_select_d;
  logic mem_write_n_q, mem_write_n_d, mem_dot_write_n_q, mem_dot_write_n_d;
  logic mem_sel_write_n_q, mem_sel_write_n_d;
  logic pop, push, ld_mem, ld_dot, ld_sel, ld_ctrl;
  logic [1:0] h_op;
  logic [MAL-1:0] h_addr, h_row, h_col;
  logic [15:0] h_data;
  logic [2:0] h_mask;
  assign pop = state_q == IDLE && fcnt_q != 2'd0 && !estop;
  // A full buffer still accepts when the head leaves in the same cycle
  assign cmd.cmd_ready = !estop && (fcnt_q != 2'd2 || pop);
  assign push = cmd.cmd_valid && cmd.cmd_ready;
  assign busy = state_q != IDLE || fcnt_q != 2'd0;
  assign {h_op, h_addr, h_row, h_col, h_data, h_mask} = buf_q[rd_q];
  assign ld_mem = pop && h_op == OP_MEM;
  assign ld_dot = pop && h_op == OP_DOT;
  assign ld_sel = pop && h_op == OP_SEL;
  assign ld_ctrl = pop && h_op == OP_CTRL;
  always_comb begin
    buf_d = buf_q;
    if (push) buf_d[wr_q] = {cmd.cmd_op, cmd.cmd_addr, cmd.cmd_row, cmd.cmd_col, cmd.cmd_data, cmd.cmd_mask};
    rd_d = rd_q ^ pop;
    wr_d = estop ? rd_q : wr_q ^ push;
    fcnt_d = estop ? 2'd0 : fcnt_q + {1'b0, push} - {1'b0, pop};
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = pop ? h_op : op_q;
    unique case (state_q)
      IDLE: if (pop) begin
        state_d = SETUP;
        cnt_d = CW'(SETUP_CYCLES - 1);
      end
      SETUP: if (estop || (cnt_q == '0 && op_q == OP_CTRL)) begin
        state_d = HOLD;
        cnt_d = CW'(HOLD_CYCLES - 1);
      end else if (cnt_q == '0) begin
        state_d = STROBE;
        cnt_d = CW'(STROBE_CYCLES - 1);
      end else cnt_d = cnt_q - 1'b1;
      STROBE: if (estop || cnt_q == '0) begin
        state_d = HOLD;
        cnt_d = CW'(HOLD_CYCLES - 1);
      end else cnt_d = cnt_q - 1'b1;
      HOLD: if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - 1'b1;
    endcase
    mem_address_d = (ld_mem || ld_dot) ? h_addr : mem_address_q;
    data_in_d = ld_mem ? h_data : data_in_q;
    mask_select_d = ld_mem ? h_mask : mask_select_q;
    row_select_d = ld_dot ? h_row : row_select_q;
    col_select_d = ld_dot ? h_col : col_select_q;
    mem_sel_col_address_d = ld_sel ? h_addr : mem_sel_col_address_q;
    row_col_select_d = ld_sel ? h_data[0] : row_col_select_q;
    inverter_select_d = ld_ctrl ? h_data[1] : inverter_select_q;
    output_active_d = estop ? 1'b0 : ld_ctrl ? h_data[0] : output_active_q;
    mem_write_n_d = !(state_d == STROBE && op_d == OP_MEM);
    mem_dot_write_n_d = !(state_d == STROBE && op_d == OP_DOT);
    mem_sel_write_n_d = !(state_d == STROBE && op_d == OP_SEL);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      fcnt_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      buf_q <= '{default: '0};
      mask_select_q <= '0;
      mem_address_q <= '0;
      row_select_q <= '0;
      col_select_q <= '0;
      mem_sel_col_address_q <= '0;
      data_in_q <= '0;
      row_col_select_q <= 1'b0;
      output_active_q <= 1'b0;
      inverter_select_q <= 1'b0;
      mem_write_n_q <= 1'b1;
      mem_dot_write_n_q <= 1'b1;
      mem_sel_write_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      fcnt_q <= fcnt_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      buf_q <= buf_d;
      mask_select_q <= mask_select_d;
      mem_address_q <= mem_address_d;
      row_select_q <= row_select_d;
      col_select_q <= col_select_d;
      mem_sel_col_address_q <= mem_sel_col_address_d;
      data_in_q <= data_in_d;
      row_col_select_q <= row_col_select_d;
      output_active_q <= output_active_d;
      inverter_select_q <= inverter_select_d;
      mem_write_n_q <= mem_write_n_d;
      mem_dot_write_n_q <= mem_dot_write_n_d;
      mem_sel_write_n_q <= mem_sel_write_n_d;
    end
  end
  assign mask_select_a = mask_select_q;
  assign mem_address_a = mem_address_q;
  assign row_select_a = row_select_q;
  assign col_select_a = col_select_q;
  assign mem_sel_col_address_a = mem_sel_col_address_q;
  assign data_in_a = data_in_q;
  assign row_col_select_a = row_col_select_q;
  assign output_active_a = output_active_q;
  assign inverter_select_a = inverter_select_q;
  assign mem_write_n_a = mem_write_n_q;
  assign mem_dot_write_n_a = mem_dot_write_n_q;
  assign mem_sel_write_n_a = mem_sel_write_n_q;
endmodule

// File: tb/tb_driver_cfg_writer.sv
// tb_driver_cfg_writer: random and directed stimulus against a timestamp-based model of the command writer
module tb_driver_cfg_writer;
  localparam int MAL = 6, S = 4, ST = 4, H = 4;
  logic clock = 1'b0, reset_n = 1'b0, estop = 1'b0;
  always #5 clock = ~clock;
  logic busy, row_col_select_a, mem_write_n_a, mem_dot_write_n_a, mem_sel_write_n_a;
  logic output_active_a, inverter_select_a;
  logic [2:0] mask_select_a;
  logic [MAL-1:0] mem_address_a, row_select_a, col_select_a, mem_sel_col_address_a;
  logic [15:0] data_in_a;
  driver_cfg_writer_if #(.MAL(MAL)) cif ();
  driver_cfg_writer #(.MEM_ADDRESS_LENGTH(MAL), .SETUP_CYCLES(S), .STROBE_CYCLES(ST), .HOLD_CYCLES(H)) dut (
    .clock(clock), .reset_n(reset_n), .cmd(cif), .estop(estop), .busy(busy),
    .mask_select_a(mask_select_a), .mem_address_a(mem_address_a), .row_select_a(row_select_a),
    .col_select_a(col_select_a), .mem_sel_col_address_a(mem_sel_col_address_a), .data_in_a(data_in_a),
    .row_col_select_a(row_col_select_a), .mem_write_n_a(mem_write_n_a), .mem_dot_write_n_a(mem_dot_write_n_a),
    .mem_sel_write_n_a(mem_sel_write_n_a), .output_active_a(output_active_a), .inverter_select_a(inverter_select_a));
  typedef struct packed {logic [1:0] op; logic [MAL-1:0] addr, row, col; logic [15:0] data; logic [2:0] mask;} cmd_t;
  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Model: accepted commands in a queue; each running op is described by the edge numbers at
  // which its strobe falls, rises and the writer returns to idle.
  cmd_t q[$];
  int cur = 0, end_t = 0, lo_t = 0, hi_t = 0;
  logic [1:0] m_op;
  logic [2:0] m_mask;
  logic [MAL-1:0] m_addr, m_row, m_col, m_sel;
  logic [15:0] m_data;
  logic m_rcs, m_act, m_inv;
  int busy_cnt, stalls, fullpp, last_rise;
  int lo_cnt[3];
  int sorder[$];
  logic last_acc, prev_low;
  logic [63:0] dut_outs;
  assign dut_outs = {14'd0, mem_write_n_a, mem_dot_write_n_a, mem_sel_write_n_a, mask_select_a, mem_address_a,
    row_select_a, col_select_a, mem_sel_col_address_a, data_in_a, row_col_select_a, output_active_a,
    inverter_select_a, busy};
  function automatic logic [63:0] exp_outs();
    logic s;
    s = lo_t <= cur && cur < hi_t;
    return {14'd0, !(s && m_op == 2'd0), !(s && m_op == 2'd1), !(s && m_op == 2'd2), m_mask, m_addr, m_row,
      m_col, m_sel, m_data, m_rcs, m_act, m_inv, (cur < end_t || q.size() > 0)};
  endfunction
  task automatic model_reset();
    q.delete();
    end_t = 0; lo_t = 0; hi_t = 0; m_op = 2'd0;
    m_mask = '0; m_addr = '0; m_row = '0; m_col = '0; m_sel = '0; m_data = '0;
    m_rcs = 1'b0; m_act = 1'b0; m_inv = 1'b0;
    prev_low = 1'b0; last_rise = -1;
  endtask
  function automatic cmd_t mk(input logic [1:0] op, input logic [MAL-1:0] addr, row, col,
                              input logic [15:0] data, input logic [2:0] mask);
    cmd_t c;
    c.op = op; c.addr = addr; c.row = row; c.col = col; c.data = data; c.mask = mask;
    return c;
  endfunction
  task automatic cyc(input logic v, input cmd_t c, input logic e);
    logic idle, pop, rdy, lowv;
    int qs, nlow;
    cmd_t h;
    cif.cmd_valid = v; cif.cmd_op = c.op; cif.cmd_addr = c.addr; cif.cmd_row = c.row;
    cif.cmd_col = c.col; cif.cmd_data = c.data; cif.cmd_mask = c.mask; estop = e;
    #2;
    idle = cur >= end_t;
    qs = q.size();
    pop = idle && qs > 0 && !e;
    rdy = !e && (qs < 2 || pop);
    check("cmd_ready", 64'(cif.cmd_ready), 64'(rdy));
    last_acc = v && rdy;
    if (v && !rdy) stalls++;
    if (last_acc && pop && qs == 2) fullpp++;
    @(posedge clock);
    if (e) begin
      q.delete();
      m_act = 1'b0;
      if (!idle && cur < lo_t) begin lo_t = cur + 1; hi_t = cur + 1; end_t = cur + 1 + H; end
      else if (!idle && cur < hi_t) begin hi_t = cur + 1; end_t = cur + 1 + H; end
    end
    cur++;
    if (pop) begin
      h = q.pop_front();
      m_op = h.op;
      lo_t = cur + S;
      hi_t = h.op == 2'd3 ? lo_t : lo_t + ST;
      end_t = hi_t + H;
      case (h.op)
        2'd0: begin m_addr = h.addr; m_data = h.data; m_mask = h.mask; end
        2'd1: begin m_addr = h.addr; m_row = h.row; m_col = h.col; end
        2'd2: begin m_sel = h.addr; m_rcs = h.data[0]; end
        default: begin m_act = h.data[0]; m_inv = h.data[1]; end
      endcase
    end
    if (last_acc) q.push_back(c);
    #1;
    check("outs", dut_outs, exp_outs());
    busy_cnt += int'(busy);
    lo_cnt[0] += int'(!mem_write_n_a);
    lo_cnt[1] += int'(!mem_dot_write_n_a);
    lo_cnt[2] += int'(!mem_sel_write_n_a);
    nlow = int'(!mem_write_n_a) + int'(!mem_dot_write_n_a) + int'(!mem_sel_write_n_a);
    check("one_strobe", 64'(nlow <= 1), 64'd1);
    lowv = nlow != 0;
    if (lowv && !prev_low) begin
      if (last_rise >= 0) check("strobe_gap", 64'(cur - last_rise >= 1 + S + H), 64'd1);
      sorder.push_back(!mem_write_n_a ? 0 : !mem_dot_write_n_a ? 1 : 2);
    end
    if (!lowv && prev_low) last_rise = cur;
    prev_low = lowv;
  endtask
  task automatic idle_n(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0);
  endtask
  task automatic send(input cmd_t c);
    int k;
    k = 0;
    do begin cyc(1'b1, c, 1'b0); k++; end while (!last_acc && k < 100);
    check("accept", 64'(last_acc), 64'd1);
  endtask
  task automatic drain(input int bound);
    int k;
    k = 0;
    while (busy && k < bound) begin cyc(1'b0, '0, 1'b0); k++; end
    check("drain", 64'(busy), 64'd0);
  endtask
  task automatic clr();
    busy_cnt = 0; stalls = 0; fullpp = 0; lo_cnt = '{0, 0, 0}; sorder.delete();
  endtask
  task automatic wait_low(input int which, input string tag);
    int k;
    logic [2:0] st;
    k = 0;
    st = {mem_sel_write_n_a, mem_dot_write_n_a, mem_write_n_a};
    while (st[which] && k < 50) begin
      cyc(1'b0, '0, 1'b0);
      k++;
      st = {mem_sel_write_n_a, mem_dot_write_n_a, mem_write_n_a};
    end
    check(tag, 64'(st[which]), 64'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    cmd_t c;
    cif.cmd_valid = 1'b0; cif.cmd_op = '0; cif.cmd_addr = '0; cif.cmd_row = '0;
    cif.cmd_col = '0; cif.cmd_data = '0; cif.cmd_mask = '0;
    model_reset();
    clr();
    repeat (2) @(posedge clock);
    #1;
    check("reset_outs", dut_outs, exp_outs());
    check("reset_ready", 64'(cif.cmd_ready), 64'd1);
    @(negedge clock) reset_n = 1'b1;
    clr();
    send(mk(2'd0, 6'd5, 6'd0, 6'd0, 16'hA5A5, 3'd3));
    idle_n(14);
    check("mem_busy_len", 64'(busy_cnt), 64'd13);
    check("mem_low_len", 64'(lo_cnt[0]), 64'd4);
    check("mem_data", 64'(data_in_a), 64'hA5A5);
    check("mem_mask", 64'(mask_select_a), 64'd3);
    clr();
    send(mk(2'd3, 6'd0, 6'd0, 6'd0, 16'h0001, 3'd0));
    idle_n(10);
    check("ctrl_busy_len", 64'(busy_cnt), 64'd9);
    check("ctrl_no_strobe", 64'(lo_cnt[0] + lo_cnt[1] + lo_cnt[2]), 64'd0);
    check("ctrl_active", 64'(output_active_a), 64'd1);
    check("ctrl_inv", 64'(inverter_select_a), 64'd0);
    clr();
    send(mk(2'd1, 6'd7, 6'd9, 6'd11, 16'h0000, 3'd0));
    send(mk(2'd2, 6'd33, 6'd0, 6'd0, 16'h0001, 3'd0));
    send(mk(2'd0, 6'd60, 6'd0, 6'd0, 16'h1234, 3'd6));
    send(mk(2'd3, 6'd0, 6'd0, 6'd0, 16'h0003, 3'd0));
    drain(200);
    check("stall_seen", 64'(stalls > 0), 64'd1);
    check("full_push_pop", 64'(fullpp > 0), 64'd1);
    check("order_len", 64'(sorder.size()), 64'd3);
    if (sorder.size() == 3) begin
      check("order0", 64'(sorder[0]), 64'd1);
      check("order1", 64'(sorder[1]), 64'd2);
      check("order2", 64'(sorder[2]), 64'd0);
    end
    check("b2b_lens", {16'd0, 16'(lo_cnt[0]), 16'(lo_cnt[1]), 16'(lo_cnt[2])}, {16'd0, 16'd4, 16'd4, 16'd4});
    check("b2b_ctrl", 64'({output_active_a, inverter_select_a}), 64'd3);
    send(mk(2'd1, 6'd3, 6'd4, 6'd5, 16'h0000, 3'd0));
    send(mk(2'd0, 6'd8, 6'd0, 6'd0, 16'h5555, 3'd1));
    wait_low(1, "dot_strobe_seen");
    clr();
    cyc(1'b1, mk(2'd2, 6'd1, 6'd0, 6'd0, 16'h0001, 3'd0), 1'b1);
    check("estop_drop", 64'(last_acc), 64'd0);
    check("estop_strobe_off", 64'(mem_dot_write_n_a), 64'd1);
    check("estop_active", 64'(output_active_a), 64'd0);
    drain(50);
    check("estop_flushed", 64'(lo_cnt[0] + lo_cnt[2]), 64'd0);
    repeat (800) begin
      c.op = 2'($urandom_range(0, 3));
      c.addr = MAL'($urandom); c.row = MAL'($urandom); c.col = MAL'($urandom);
      c.data = 16'($urandom); c.mask = 3'($urandom);
      cyc(1'($urandom_range(0, 1)), c, $urandom_range(0, 39) == 0);
    end
    drain(200);
    send(mk(2'd0, 6'd21, 6'd0, 6'd0, 16'hBEEF, 3'd5));
    wait_low(0, "mem_strobe_seen");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_outs", dut_outs, exp_outs());
    check("async_reset_strobe", 64'(mem_write_n_a), 64'd1);
    check("async_reset_busy", 64'(busy), 64'd0);
    @(negedge clock) reset_n = 1'b1;
    idle_n(2);
    clr();
    send(mk(2'd2, 6'd40, 6'd0, 6'd0, 16'h0000, 3'd0));
    drain(50);
    check("post_reset_sel", 64'(lo_cnt[2]), 64'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
